// File: rtl/ahb_to_apb_pkg.sv
// Shared AHB-Lite/APB encodings and the bridge state type.
package ahb_to_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  // NONSEQ and SEQ both request a real transfer; IDLE and BUSY never do.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_to_apb.sv
// AHB-Lite slave to APB master bridge: one AHB transfer at a time becomes an
// APB SETUP/ACCESS pair, with the AHB data phase stretched until pready_i.
module ahb_to_apb
  import ahb_to_apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int HBURST_WIDTH = 2,
  parameter int HPROT_WIDTH  = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   haddr_i,
  input  logic [HBURST_WIDTH-1:0] hburst_i,
  input  logic                    hmastlock_i,
  input  logic                    hsel_i,
  input  logic [HPROT_WIDTH-1:0]  hprot_i,
  input  logic [2:0]              hsize_i,
  input  logic                    hnonsec_i,
  input  logic                    hexcl_i,
  input  logic                    hmaster_i,
  input  logic [1:0]              htrans_i,
  input  logic [DATA_WIDTH-1:0]   hwdata_i,
  input  logic [DATA_WIDTH/8-1:0] hwstrb_i,
  input  logic                    hwrite_i,
  output logic [DATA_WIDTH-1:0]   hrdata_o,
  output logic                    hready_o,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  output logic                    hexokay_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penabe_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i
);

  apb_state_e            state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic xfer_done;
  logic bridge_ready;
  logic accept;

  assign xfer_done    = (state_q == APB_ACCESS) && pready_i;
  assign bridge_ready = (state_q == APB_IDLE) || xfer_done;
  assign accept       = hsel_i && is_active_trans(htrans_i) && bridge_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= APB_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      hrdata_q  <= '0;
    end else begin
      case (state_q)
        APB_IDLE: begin
          if (accept) begin
            state_q <= APB_SETUP;
            psel_q  <= 1'b1;
          end
        end
        APB_SETUP: begin
          state_q   <= APB_ACCESS;
          penable_q <= 1'b1;
        end
        APB_ACCESS: begin
          // A back-to-back accept keeps psel high and goes straight to SETUP.
          if (pready_i) begin
            state_q   <= accept ? APB_SETUP : APB_IDLE;
            psel_q    <= accept;
            penable_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= APB_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase

      if (accept) begin
        paddr_q  <= haddr_i;
        pwrite_q <= hwrite_i;
      end
      if (xfer_done && !pwrite_q) begin
        hrdata_q <= prdata_i;
      end
    end
  end

  // Write data comes straight from the AHB data phase, which the master holds
  // for as long as hreadyout_o is low.
  assign pwdata_o    = (psel_q && pwrite_q) ? hwdata_i : '0;
  assign pstrb_o     = (psel_q && pwrite_q) ? hwstrb_i : '0;
  assign hrdata_o    = xfer_done ? prdata_i : hrdata_q;
  assign hreadyout_o = bridge_ready;
  assign hready_o    = bridge_ready;
  assign hresp_o     = 1'b0;
  assign hexokay_o   = 1'b0;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign psel_o      = psel_q;
  assign penabe_o    = penable_q;

  logic unused_sideband;
  assign unused_sideband = ^{hburst_i, hmastlock_i, hprot_i, hsize_i,
                             hnonsec_i, hexcl_i, hmaster_i};

endmodule

// File: tb/tb_ahb_to_apb.sv
// Randomized scoreboard bench for ahb_to_apb: an AHB master driver, an APB
// slave with a byte-addressed memory, and a reference memory model.
module tb_ahb_to_apb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] haddr_i = '0;
  logic [1:0]  hburst_i = '0;
  logic        hmastlock_i = 1'b0;
  logic        hsel_i = 1'b0;
  logic [3:0]  hprot_i = '0;
  logic [2:0]  hsize_i = 3'd2;
  logic        hnonsec_i = 1'b0;
  logic        hexcl_i = 1'b0;
  logic        hmaster_i = 1'b0;
  logic [1:0]  htrans_i = 2'b00;
  logic [31:0] hwdata_i = '0;
  logic [3:0]  hwstrb_i = '0;
  logic        hwrite_i = 1'b0;
  logic [31:0] hrdata_o;
  logic        hready_o, hreadyout_o, hresp_o, hexokay_o;
  logic [31:0] paddr_o;
  logic        psel_o, penabe_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b1;

  ahb_to_apb dut (
    .clk(clk), .reset(reset),
    .haddr_i(haddr_i), .hburst_i(hburst_i), .hmastlock_i(hmastlock_i),
    .hsel_i(hsel_i), .hprot_i(hprot_i), .hsize_i(hsize_i),
    .hnonsec_i(hnonsec_i), .hexcl_i(hexcl_i), .hmaster_i(hmaster_i),
    .htrans_i(htrans_i), .hwdata_i(hwdata_i), .hwstrb_i(hwstrb_i),
    .hwrite_i(hwrite_i), .hrdata_o(hrdata_o), .hready_o(hready_o),
    .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .hexokay_o(hexokay_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penabe_o(penabe_o),
    .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } resp_t;

  xfer_t xq[$];
  xfer_t apb_q[$];
  resp_t ahb_q[$];

  logic [31:0] ref_mem [16];
  logic [31:0] slave_mem [16];

  int total = 0;
  int bad = 0;

  bit rand_waits = 0;
  int fixed_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Activity counters sampled between edges; tests compare before/after deltas.
  int low_cnt = 0, psel_cnt = 0, en_cnt = 0, rise_cnt = 0;
  bit psel_prev = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (!hready_o) low_cnt++;
      if (psel_o) psel_cnt++;
      if (penabe_o) en_cnt++;
      if (psel_o && !psel_prev) rise_cnt++;
      psel_prev = psel_o;
    end else begin
      psel_prev = 0;
    end
  end

  // APB slave: memory-backed, inserts cur_wait wait states per ACCESS.
  initial begin : apb_slave
    bit done;
    bit started;
    int wait_cnt;
    int cur_wait;
    started = 0; wait_cnt = 0; cur_wait = 0;
    forever begin
      @(negedge clk);
      done = reset && psel_o && penabe_o && pready_i;
      if (done && pwrite_o)
        slave_mem[paddr_o[5:2]] = merge(slave_mem[paddr_o[5:2]], pwdata_o, pstrb_o);
      @(posedge clk);
      #1;
      if (!reset || done) begin
        started = 0;
        wait_cnt = 0;
      end
      if (penabe_o && !started) begin
        started = 1;
        cur_wait = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
      end
      if (started && wait_cnt < cur_wait) begin
        pready_i = 1'b0;
        wait_cnt++;
      end else begin
        pready_i = 1'b1;
      end
      prdata_i = slave_mem[paddr_o[5:2]];
    end
  end

  // Monitor: pops expectations whenever an APB transfer or AHB data phase completes.
  initial begin : monitor
    bit dp;
    xfer_t ea;
    resp_t er;
    dp = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dp = 0;
      end else begin
        if (psel_o && penabe_o && pready_i) begin
          if (apb_q.size() == 0) begin
            chk("apb_unexpected_xfer", 64'(paddr_o), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            ea = apb_q.pop_front();
            $display("apb %s addr=0x%08h wdata=0x%08h strb=%h prdata=0x%08h",
                     pwrite_o ? "wr" : "rd", paddr_o, pwdata_o, pstrb_o, prdata_i);
            chk("paddr", 64'(paddr_o), 64'(ea.addr));
            chk("pwrite", 64'(pwrite_o), 64'(ea.wr));
            if (ea.wr) begin
              chk("pwdata", 64'(pwdata_o), 64'(ea.wdata));
              chk("pstrb", 64'(pstrb_o), 64'(ea.strb));
            end
          end
        end
        if (dp && hready_o) begin
          if (ahb_q.size() == 0) begin
            chk("ahb_unexpected_resp", 64'(hrdata_o), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            er = ahb_q.pop_front();
            chk("hresp", 64'(hresp_o), 64'd0);
            if (!er.wr) chk("hrdata", 64'(hrdata_o), 64'(er.rdata));
          end
          dp = 0;
        end
        if (hready_o) dp = hsel_i && htrans_i[1];
      end
    end
  end

  task automatic add(input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s);
    xfer_t x;
    x.trans = t; x.addr = a; x.wr = w; x.wdata = d; x.strb = s;
    xq.push_back(x);
  endtask

  task automatic drive_ap(input bit v, input xfer_t ap);
    hburst_i  = 2'($urandom);
    hprot_i   = 4'($urandom);
    hsize_i   = 3'($urandom);
    hmastlock_i = 1'($urandom);
    hnonsec_i = 1'($urandom);
    hexcl_i   = 1'($urandom);
    hmaster_i = 1'($urandom);
    if (v) begin
      htrans_i = ap.trans;
      haddr_i  = ap.addr;
      hwrite_i = ap.wr;
    end else begin
      htrans_i = 2'b00;
    end
  endtask

  // Pipelined AHB master: issues every entry of xq, called just after a posedge.
  task automatic run_stream();
    xfer_t ap;
    bit ap_v, dp_v, rdy;
    int guard;
    hsel_i = 1'b1;
    ap_v = (xq.size() > 0);
    if (ap_v) ap = xq.pop_front();
    drive_ap(ap_v, ap);
    dp_v = 0;
    guard = 0;
    while ((ap_v || dp_v) && guard < 2000) begin
      @(negedge clk);
      rdy = hready_o;
      @(posedge clk);
      #1;
      guard++;
      if (rdy) begin
        if (ap_v && ap.trans[1]) begin
          apb_q.push_back(ap);
          if (ap.wr) begin
            ref_mem[ap.addr[5:2]] = merge(ref_mem[ap.addr[5:2]], ap.wdata, ap.strb);
            ahb_q.push_back({1'b1, 32'h0});
          end else begin
            ahb_q.push_back({1'b0, ref_mem[ap.addr[5:2]]});
          end
          hwdata_i = ap.wdata;
          hwstrb_i = ap.strb;
          dp_v = 1;
        end else begin
          dp_v = 0;
        end
        ap_v = (xq.size() > 0);
        if (ap_v) ap = xq.pop_front();
        drive_ap(ap_v, ap);
      end
    end
    if (guard >= 2000) chk("stream_timeout", 64'(guard), 64'd0);
    htrans_i = 2'b00;
    hsel_i = 1'b0;
    xq.delete();
  endtask

  task automatic chk_drained(input string name);
    @(negedge clk);
    chk({name, "_apb_q"}, 64'(apb_q.size()), 64'd0);
    chk({name, "_ahb_q"}, 64'(ahb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int l0, p0, e0, r0, k;
    logic [1:0] t;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'h1234_5678;
    slave_mem[4] = 32'h1234_5678;

    // Reset values, checked in reset and after release with hsel low.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hreadyout", 64'(hreadyout_o), 64'd1);
    chk("rst_psel", 64'(psel_o), 64'd0);
    chk("rst_penable", 64'(penabe_o), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hreadyout", 64'(hreadyout_o), 64'd1);
    chk("idle_hready", 64'(hready_o), 64'd1);
    chk("idle_psel", 64'(psel_o), 64'd0);
    chk("idle_hresp", 64'(hresp_o), 64'd0);
    chk("idle_hexokay", 64'(hexokay_o), 64'd0);
    chk("idle_hrdata", 64'(hrdata_o), 64'd0);
    chk("idle_paddr", 64'(paddr_o), 64'd0);
    chk("idle_pwdata", 64'(pwdata_o), 64'd0);
    @(posedge clk);
    #1;

    // Single zero-wait write.
    fixed_wait = 0;
    l0 = low_cnt; p0 = psel_cnt; e0 = en_cnt;
    add(2'b10, 32'h0000_000C, 1'b1, 32'hA5A5_5A5A, 4'hF);
    run_stream();
    chk("wr_low_cycles", 64'(low_cnt - l0), 64'd1);
    chk("wr_psel_cycles", 64'(psel_cnt - p0), 64'd2);
    chk("wr_penable_cycles", 64'(en_cnt - e0), 64'd1);
    chk_drained("wr");

    // Read with three wait states.
    fixed_wait = 3;
    l0 = low_cnt; p0 = psel_cnt; e0 = en_cnt;
    add(2'b10, 32'h0000_0010, 1'b0, 32'h0, 4'h0);
    run_stream();
    chk("rd_low_cycles", 64'(low_cnt - l0), 64'd4);
    chk("rd_psel_cycles", 64'(psel_cnt - p0), 64'd5);
    chk("rd_penable_cycles", 64'(en_cnt - e0), 64'd4);
    chk_drained("rd");

    // INCR4 write burst: back to back, psel never drops.
    fixed_wait = 0;
    l0 = low_cnt; p0 = psel_cnt; e0 = en_cnt; r0 = rise_cnt;
    for (int i = 0; i < 4; i++)
      add((i == 0) ? 2'b10 : 2'b11, 32'h0000_000C + 32'(4 * i), 1'b1, $urandom, 4'hF);
    run_stream();
    chk("burst_psel_cycles", 64'(psel_cnt - p0), 64'd8);
    chk("burst_penable_cycles", 64'(en_cnt - e0), 64'd4);
    chk("burst_psel_rises", 64'(rise_cnt - r0), 64'd1);
    chk("burst_low_cycles", 64'(low_cnt - l0), 64'd4);
    chk_drained("burst");

    // BUSY / IDLE with hsel high: no APB activity, no wait states.
    l0 = low_cnt; p0 = psel_cnt;
    add(2'b01, 32'h0000_0020, 1'b1, 32'h0, 4'hF);
    add(2'b00, 32'h0000_0024, 1'b0, 32'h0, 4'h0);
    add(2'b01, 32'h0000_0028, 1'b0, 32'h0, 4'h0);
    add(2'b00, 32'h0000_002C, 1'b1, 32'h0, 4'hF);
    run_stream();
    chk("busy_psel_cycles", 64'(psel_cnt - p0), 64'd0);
    chk("busy_low_cycles", 64'(low_cnt - l0), 64'd0);
    chk_drained("busy");

    // Randomized mixed traffic with random wait states.
    rand_waits = 1;
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      t = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k < 6) ? 2'b10 : 2'b11;
      add(t, {$urandom_range(0, 255), 24'h0} | 32'({$urandom_range(0, 15), 2'b00}),
          1'($urandom), $urandom, 4'($urandom));
    end
    run_stream();
    chk_drained("rand");
    rand_waits = 0;

    // Reset asserted during ACCESS aborts the transfer immediately.
    fixed_wait = 5;
    hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0000_0020; hwrite_i = 1'b0;
    @(posedge clk);
    #1;
    htrans_i = 2'b00; hsel_i = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!penabe_o && k < 20);
    chk("abort_reach_access", 64'(penabe_o), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_psel", 64'(psel_o), 64'd0);
    chk("abort_penable", 64'(penabe_o), 64'd0);
    chk("abort_hreadyout", 64'(hreadyout_o), 64'd1);
    repeat (2) @(negedge clk);
    apb_q.delete();
    ahb_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_psel", 64'(psel_o), 64'd0);
    chk("post_rst_hreadyout", 64'(hreadyout_o), 64'd1);
    @(posedge clk);
    #1;

    // Recovery after abort: write then read back the same word.
    fixed_wait = 1;
    add(2'b10, 32'h0000_0030, 1'b1, 32'hCAFE_F00D, 4'hF);
    add(2'b10, 32'h0000_0030, 1'b0, 32'h0, 4'h0);
    run_stream();
    chk_drained("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
